// File: rtl/xprog_mem_pkg.sv
// rtl/xprog_mem_pkg.sv - default widths, FSM states and boot ROM image function for xprog_mem
package xprog_mem_pkg;
    localparam int INSTR_W_DEF     = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int ROM_ADDR_W_DEF  = 8;
    localparam int RAM_ADDR_W_DEF  = 10;
    localparam int PROG_ADDR_W_DEF = 11;
    localparam int BOOT_LEN_DEF    = 256;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Boot image: word k holds k + 0x100.
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return addr + 32'h0000_0100;
    endfunction
endpackage

// File: rtl/xprog_mem_if.sv
// rtl/xprog_mem_if.sv - host data port (and DMA port when XPROG_DMA_EN is defined) into program RAM
interface xprog_mem_if #(
    parameter int DATA_W     = 32,
    parameter int RAM_ADDR_W = 10
);
    logic                  data_sel;
    logic                  data_we;
    logic [RAM_ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0]     data_in;
    logic                  data_ready;
    logic [DATA_W-1:0]     data_out;
`ifdef XPROG_DMA_EN
    logic                  dma_sel;
    logic                  dma_we;
    logic [RAM_ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0]     dma_data_in;
    logic                  dma_ready;
    logic [DATA_W-1:0]     dma_data_out;

    modport master (output data_sel, data_we, data_addr, data_in, dma_sel, dma_we, dma_addr, dma_data_in,
                    input  data_ready, data_out, dma_ready, dma_data_out);
    modport slave  (input  data_sel, data_we, data_addr, data_in, dma_sel, dma_we, dma_addr, dma_data_in,
                    output data_ready, data_out, dma_ready, dma_data_out);
`else
    modport master (output data_sel, data_we, data_addr, data_in,
                    input  data_ready, data_out);
    modport slave  (input  data_sel, data_we, data_addr, data_in,
                    output data_ready, data_out);
`endif
endinterface

// File: rtl/xprog_ram2p.sv
// rtl/xprog_ram2p.sv - program RAM: port A sync read (fetch), port B sync read/write, read-first
module xprog_ram2p #(
    parameter int W  = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          a_en,
    input  logic [AW-1:0] a_addr,
    output logic [W-1:0]  a_rdata,
    input  logic          b_en,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [W-1:0]  b_wdata,
    output logic [W-1:0]  b_rdata
);
    logic [W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (a_en) begin
            a_rdata <= mem[a_addr];
        end
    end

    // Port B read data only updates on reads so it can be held by the owner.
    always_ff @(posedge clk) begin
        if (b_en) begin
            if (b_we) begin
                mem[b_addr] <= b_wdata;
            end else begin
                b_rdata <= mem[b_addr];
            end
        end
    end
endmodule

// File: rtl/xprog_rom.sv
// rtl/xprog_rom.sv - boot ROM, synchronous read with one cycle latency
module xprog_rom
    import xprog_mem_pkg::*;
#(
    parameter int W  = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [W-1:0]  rdata
);
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= W'(rom_word(32'(addr)));
        end
    end
endmodule

// File: rtl/xprog_mem.sv
// rtl/xprog_mem.sv - boot ROM + program RAM with boot copier and port B arbiter; XPROG_DMA_EN adds DMA port
module xprog_mem
    import xprog_mem_pkg::*;
#(
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ROM_ADDR_W  = ROM_ADDR_W_DEF,
    parameter int RAM_ADDR_W  = RAM_ADDR_W_DEF,
    parameter int PROG_ADDR_W = PROG_ADDR_W_DEF,
    parameter int BOOT_LEN    = BOOT_LEN_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   boot_req,
    output logic                   boot_busy,
    input  logic                   fetch_en,
    input  logic [PROG_ADDR_W-1:0] pc,
    output logic [INSTR_W-1:0]     instruction,
    output logic                   instr_valid,
    xprog_mem_if.slave             bus
);
    localparam int SEL_BIT = PROG_ADDR_W - 1;
    localparam int CNT_W   = ROM_ADDR_W + 1;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  fetched, src_ram;
    logic                  data_rd_q;
    logic [DATA_W-1:0]     data_hold;
    logic                  booting, fetch_go, boot_wr;
    logic                  rom_en, ram_a_en;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [INSTR_W-1:0]    rom_rdata, ram_a_rdata, b_rdata, b_wdata;
    logic                  b_en, b_we;
    logic [RAM_ADDR_W-1:0] b_addr;
    logic                  data_ready;

    wire unused_bits = ^{pc, bus.data_in};

    assign booting  = (state == ST_BOOT);
    assign fetch_go = ~booting & fetch_en & ~boot_req;
    assign boot_wr  = booting & (cnt != '0);
    // ROM is shared: the copier owns it while booting, fetch owns it in RUN.
    assign rom_en   = booting | (fetch_go & ~pc[SEL_BIT]);
    assign rom_addr = booting ? cnt[ROM_ADDR_W-1:0] : pc[ROM_ADDR_W-1:0];
    assign ram_a_en = fetch_go & pc[SEL_BIT];

    assign data_ready     = bus.data_sel & ~boot_busy;
    assign bus.data_ready = data_ready;
    assign bus.data_out   = data_rd_q ? DATA_W'(b_rdata) : data_hold;
    assign instruction    = fetched ? (src_ram ? ram_a_rdata : rom_rdata) : '0;

`ifdef XPROG_DMA_EN
    logic              dma_ready, dma_rd_q;
    logic [DATA_W-1:0] dma_hold;
    wire unused_dma = ^bus.dma_data_in;

    assign dma_ready        = bus.dma_sel & ~boot_busy & ~bus.data_sel;
    assign bus.dma_ready    = dma_ready;
    assign bus.dma_data_out = dma_rd_q ? DATA_W'(b_rdata) : dma_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_rd_q <= 1'b0;
            dma_hold <= '0;
        end else begin
            dma_rd_q <= dma_ready & ~bus.dma_we;
            if (dma_rd_q) dma_hold <= DATA_W'(b_rdata);
        end
    end
`endif

    // Port B owner: boot copier > data > DMA.
    always_comb begin
        b_en    = 1'b0;
        b_we    = 1'b0;
        b_addr  = RAM_ADDR_W'(cnt - CNT_W'(1));
        b_wdata = rom_rdata;
        if (boot_wr) begin
            b_en = 1'b1;
            b_we = 1'b1;
        end else if (data_ready) begin
            b_en    = 1'b1;
            b_we    = bus.data_we;
            b_addr  = bus.data_addr;
            b_wdata = bus.data_in[INSTR_W-1:0];
        end
`ifdef XPROG_DMA_EN
        else if (dma_ready) begin
            b_en    = 1'b1;
            b_we    = bus.dma_we;
            b_addr  = bus.dma_addr;
            b_wdata = bus.dma_data_in[INSTR_W-1:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BOOT;
            cnt         <= '0;
            boot_busy   <= 1'b1;
            instr_valid <= 1'b0;
            fetched     <= 1'b0;
            src_ram     <= 1'b0;
            data_rd_q   <= 1'b0;
            data_hold   <= '0;
        end else begin
            data_rd_q <= data_ready & ~bus.data_we;
            if (data_rd_q) data_hold <= DATA_W'(b_rdata);
            case (state)
                ST_BOOT: begin
                    instr_valid <= 1'b0;
                    cnt         <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BOOT_LEN)) begin
                        state     <= ST_RUN;
                        boot_busy <= 1'b0;
                    end
                end
                default: begin
                    if (boot_req) begin
                        state       <= ST_BOOT;
                        cnt         <= '0;
                        boot_busy   <= 1'b1;
                        instr_valid <= 1'b0;
                    end else if (fetch_en) begin
                        instr_valid <= 1'b1;
                        fetched     <= 1'b1;
                        src_ram     <= pc[SEL_BIT];
                    end
                end
            endcase
        end
    end

    xprog_rom #(.W(INSTR_W), .AW(ROM_ADDR_W)) u_rom (
        .clk   (clk),
        .en    (rom_en),
        .addr  (rom_addr),
        .rdata (rom_rdata)
    );

    xprog_ram2p #(.W(INSTR_W), .AW(RAM_ADDR_W)) u_ram (
        .clk     (clk),
        .a_en    (ram_a_en),
        .a_addr  (pc[RAM_ADDR_W-1:0]),
        .a_rdata (ram_a_rdata),
        .b_en    (b_en),
        .b_we    (b_we),
        .b_addr  (b_addr),
        .b_wdata (b_wdata),
        .b_rdata (b_rdata)
    );
endmodule

// File: tb/tb_xprog_mem.sv
// tb/tb_xprog_mem.sv - directed self-checking bench for xprog_mem
module tb_xprog_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_req = 1'b0;
    logic        boot_busy;
    logic        fetch_en = 1'b0;
    logic [10:0] pc = '0;
    logic [31:0] instruction;
    logic        instr_valid;
    int          errors = 0;
    int          checks = 0;

    xprog_mem_if #(.DATA_W(32), .RAM_ADDR_W(10)) bus ();

    xprog_mem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .boot_req    (boot_req),
        .boot_busy   (boot_busy),
        .fetch_en    (fetch_en),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic wait_boot(output int n);
        n = 0;
        while (boot_busy === 1'b1 && n < 2000) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
    endtask

    task automatic do_fetch(input logic [10:0] p);
        fetch_en = 1'b1; pc = p;
        @(posedge clk); @(negedge clk);
        fetch_en = 1'b0;
    endtask

    task automatic host_read(input logic [9:0] a, output logic rdy, output logic [31:0] v);
        bus.data_sel = 1'b1; bus.data_we = 1'b0; bus.data_addr = a;
        #1 rdy = bus.data_ready;
        @(posedge clk); @(negedge clk);
        bus.data_sel = 1'b0;
        v = bus.data_out;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus.data_sel = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (boot_busy !== 1'b1) begin errors++; $display("FAIL reset_boot_busy got=%0b exp=1", boot_busy); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got=%0b exp=0", instr_valid); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instruction got=%h exp=0", instruction); end
        checks++; if (bus.data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out got=%h exp=0", bus.data_out); end
        checks++; if (bus.data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready got=%0b exp=0", bus.data_ready); end
        bus.data_sel = 1'b0;
    endtask

    task automatic test_boot;
        int n; logic r; logic [31:0] v;
        rst_n = 1'b1;
        wait_boot(n);
        checks++; if (n != 257) begin errors++; $display("FAIL boot_cycles got=%0d exp=257", n); end
        host_read(10'd0, r, v);
        checks++; if (r !== 1'b1) begin errors++; $display("FAIL boot_read_ready got=%0b exp=1", r); end
        checks++; if (v !== 32'h100) begin errors++; $display("FAIL boot_ram0 got=%h exp=100", v); end
        host_read(10'd128, r, v);
        checks++; if (v !== 32'h180) begin errors++; $display("FAIL boot_ram128 got=%h exp=180", v); end
        host_read(10'd255, r, v);
        checks++; if (v !== 32'h1FF) begin errors++; $display("FAIL boot_ram255 got=%h exp=1ff", v); end
        @(posedge clk); @(negedge clk);
        checks++; if (bus.data_out !== 32'h1FF) begin errors++; $display("FAIL data_out_hold got=%h exp=1ff", bus.data_out); end
    endtask

    task automatic test_fetch;
        do_fetch(11'h405);
        checks++; if (instruction !== 32'h105 || instr_valid !== 1'b1) begin errors++; $display("FAIL fetch_ram5 got=%h/%0b exp=105/1", instruction, instr_valid); end
        do_fetch(11'h07F);
        checks++; if (instruction !== 32'h17F) begin errors++; $display("FAIL fetch_rom7f got=%h exp=17f", instruction); end
        do_fetch(11'h005);
        checks++; if (instruction !== 32'h105) begin errors++; $display("FAIL fetch_rom5 got=%h exp=105", instruction); end
        do_fetch(11'h4FE);
        checks++; if (instruction !== 32'h1FE) begin errors++; $display("FAIL fetch_ram_fe got=%h exp=1fe", instruction); end
        pc = 11'h400;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        checks++; if (instruction !== 32'h1FE || instr_valid !== 1'b1) begin errors++; $display("FAIL fetch_hold got=%h/%0b exp=1fe/1", instruction, instr_valid); end
    endtask

    task automatic test_collision;
        logic r; logic [31:0] v;
        bus.data_sel = 1'b1; bus.data_we = 1'b1; bus.data_addr = 10'd3; bus.data_in = 32'h0000_DEAD;
        fetch_en = 1'b1; pc = 11'h403;
        #1;
        checks++; if (bus.data_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got=%0b exp=1", bus.data_ready); end
        @(posedge clk); @(negedge clk);
        bus.data_sel = 1'b0; bus.data_we = 1'b0; fetch_en = 1'b0;
        checks++; if (instruction !== 32'h103) begin errors++; $display("FAIL collide_old got=%h exp=103", instruction); end
        checks++; if (bus.data_out !== 32'h1FF) begin errors++; $display("FAIL wr_no_out_change got=%h exp=1ff", bus.data_out); end
        do_fetch(11'h403);
        checks++; if (instruction !== 32'hDEAD) begin errors++; $display("FAIL collide_new got=%h exp=dead", instruction); end
        host_read(10'd3, r, v);
        checks++; if (v !== 32'hDEAD) begin errors++; $display("FAIL read_back3 got=%h exp=dead", v); end
    endtask

    task automatic test_boot_req;
        int n; logic r; logic [31:0] v;
        boot_req = 1'b1;
        @(posedge clk); @(negedge clk);
        boot_req = 1'b0;
        fetch_en = 1'b1; pc = 11'h403;
        bus.data_sel = 1'b1; bus.data_we = 1'b0; bus.data_addr = 10'd3;
        checks++; if (instr_valid !== 1'b0 || boot_busy !== 1'b1) begin errors++; $display("FAIL bootreq_state got=%0b/%0b exp=0/1", instr_valid, boot_busy); end
        repeat (10) begin @(posedge clk); @(negedge clk); end
        checks++; if (instr_valid !== 1'b0 || bus.data_ready !== 1'b0) begin errors++; $display("FAIL bootreq_blocked got=%0b/%0b exp=0/0", instr_valid, bus.data_ready); end
        bus.data_sel = 1'b0; fetch_en = 1'b0;
        wait_boot(n);
        checks++; if (n != 247) begin errors++; $display("FAIL bootreq_cycles got=%0d exp=247", n); end
        host_read(10'd3, r, v);
        checks++; if (v !== 32'h103) begin errors++; $display("FAIL bootreq_ram3 got=%h exp=103", v); end
    endtask

    task automatic test_reset_mid_boot;
        int n; logic r; logic [31:0] v;
        do_fetch(11'h410);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || instruction !== 32'h0 || bus.data_out !== 32'h0) begin errors++; $display("FAIL async_reset got=%0b/%h/%h exp=0/0/0", instr_valid, instruction, bus.data_out); end
        @(negedge clk) rst_n = 1'b1;
        repeat (50) begin @(posedge clk); @(negedge clk); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (boot_busy !== 1'b1) begin errors++; $display("FAIL midboot_busy got=%0b exp=1", boot_busy); end
        @(negedge clk) rst_n = 1'b1;
        wait_boot(n);
        checks++; if (n != 257) begin errors++; $display("FAIL midboot_cycles got=%0d exp=257", n); end
        host_read(10'd200, r, v);
        checks++; if (v !== 32'h1C8) begin errors++; $display("FAIL midboot_ram200 got=%h exp=1c8", v); end
    endtask

`ifdef XPROG_DMA_EN
    task automatic test_dma;
        bus.data_sel = 1'b1; bus.data_we = 1'b0; bus.data_addr = 10'd7;
        bus.dma_sel = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 10'd9;
        #1;
        checks++; if (bus.data_ready !== 1'b1 || bus.dma_ready !== 1'b0) begin errors++; $display("FAIL arb_both got=%0b/%0b exp=1/0", bus.data_ready, bus.dma_ready); end
        @(posedge clk); @(negedge clk);
        bus.data_sel = 1'b0;
        #1;
        checks++; if (bus.dma_ready !== 1'b1) begin errors++; $display("FAIL arb_dma got=%0b exp=1", bus.dma_ready); end
        checks++; if (bus.data_out !== 32'h107) begin errors++; $display("FAIL arb_data_out got=%h exp=107", bus.data_out); end
        @(posedge clk); @(negedge clk);
        bus.dma_sel = 1'b0;
        checks++; if (bus.dma_data_out !== 32'h109) begin errors++; $display("FAIL dma_out got=%h exp=109", bus.dma_data_out); end
    endtask
`endif

    initial begin
        bus.data_sel = 1'b0; bus.data_we = 1'b0; bus.data_addr = '0; bus.data_in = '0;
`ifdef XPROG_DMA_EN
        bus.dma_sel = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_data_in = '0;
`endif
        test_reset;
        test_boot;
        test_fetch;
        test_collision;
        test_boot_req;
        test_reset_mid_boot;
`ifdef XPROG_DMA_EN
        test_dma;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
